// File: rtl/pwm_capture_nbit.sv
// PWM input capture: measures period and active time of cap_in in sys_clk cycles
// and publishes both together with a one-cycle cap_valid strobe.
module pwm_capture_nbit #(
    parameter int N           = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         en,
    input  logic         pol,
    input  logic         clr,
    input  logic         cap_in,
    output logic [N-1:0] period,
    output logic [N-1:0] high_time,
    output logic         cap_valid,
    output logic         ovf_flag,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] LOW  = 2'd3;

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = N'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sigDly_q;
    logic                   sig;
    logic                   rise;
    logic                   fall;

    logic [1:0]   state_q,    state_d;
    logic [N-1:0] cnt_q,      cnt_d;
    logic [N-1:0] hiLat_q,    hiLat_d;
    logic [N-1:0] period_q,   period_d;
    logic [N-1:0] highTime_q, highTime_d;
    logic         capValid_q, capValid_d;
    logic         ovf_q,      ovf_d;

    assign sig  = sync_q[SYNC_STAGES-1] ^ pol;
    assign rise = sig & ~sigDly_q;
    assign fall = ~sig & sigDly_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q   <= '0;
            sigDly_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], cap_in};
            sigDly_q <= sig;
        end
    end

    // clr outranks en, and both outrank the measurement FSM; a coincident edge is dropped.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hiLat_d    = hiLat_q;
        period_d   = period_q;
        highTime_d = highTime_q;
        capValid_d = 1'b0;
        ovf_d      = ovf_q;
        if (clr) begin
            period_d   = '0;
            highTime_d = '0;
            ovf_d      = 1'b0;
            cnt_d      = '0;
            hiLat_d    = '0;
            state_d    = en ? ARM : IDLE;
        end else if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hiLat_d = cnt_q;
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = LOW;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_d   = cnt_q;
                        highTime_d = hiLat_q;
                        capValid_d = 1'b1;
                        cnt_d      = CNT_ONE;
                        state_d    = HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hiLat_q    <= '0;
            period_q   <= '0;
            highTime_q <= '0;
            capValid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hiLat_q    <= hiLat_d;
            period_q   <= period_d;
            highTime_q <= highTime_d;
            capValid_q <= capValid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign period    = period_q;
    assign high_time = highTime_q;
    assign cap_valid = capValid_q;
    assign ovf_flag  = ovf_q;
    assign busy      = (state_q == HIGH) || (state_q == LOW);

endmodule

// File: tb/tb_pwm_capture_nbit.sv
// Scoreboard bench for pwm_capture_nbit: a waveform-level model predicts each
// (period, high_time) pair as the stimulus is driven; a monitor checks each strobe.
module tb_pwm_capture_nbit;

    localparam int N    = 8;
    localparam int MAXV = 255;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic         en;
    logic         pol;
    logic         clr;
    logic         cap_in;
    logic [N-1:0] period;
    logic [N-1:0] high_time;
    logic         cap_valid;
    logic         ovf_flag;
    logic         busy;

    pwm_capture_nbit #(.N(N), .SYNC_STAGES(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .pol       (pol),
        .clr       (clr),
        .cap_in    (cap_in),
        .period    (period),
        .high_time (high_time),
        .cap_valid (cap_valid),
        .ovf_flag  (ovf_flag),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int per;
        int hi;
        int due;
    } expect_t;

    expect_t expQ[$];
    expect_t monE;
    int      testsRun    = 0;
    int      testsFailed = 0;
    int      edgeCount   = 0;
    int      tNow        = 0;
    int      lastRise    = 0;
    int      lastFall    = 0;
    bit      haveRise    = 1'b0;
    bit      prevAct     = 1'b0;

    always @(posedge sys_clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge sys_clk);
        tNow += n;
    endtask

    task automatic rearmModel();
        haveRise = 1'b0;
        prevAct  = cap_in ^ pol;
    endtask

    // Drive one constant segment of cap_in; every active rise after the first
    // closes a period, unless the interval exceeded the counter range.
    task automatic applyStimulus(input logic level, input int n);
        bit      act;
        expect_t e;
        act    = level ^ pol;
        cap_in = level;
        if (act && !prevAct) begin
            if (haveRise && (tNow - lastRise) <= MAXV) begin
                e.per = tNow - lastRise;
                e.hi  = lastFall - lastRise;
                e.due = edgeCount + 3;
                expQ.push_back(e);
            end
            lastRise = tNow;
            haveRise = 1'b1;
        end else if (!act && prevAct) begin
            lastFall = tNow;
        end
        prevAct = act;
        idleCycles(n);
    endtask

    task automatic checkDrained(input string name);
        checkOutput(name, expQ.size(), 0);
        expQ.delete();
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n && cap_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_strobe", 1, 0);
            end else begin
                monE = expQ.pop_front();
                checkOutput("period", period, monE.per);
                checkOutput("high_time", high_time, monE.hi);
                checkOutput("strobe_latency", edgeCount, monE.due);
            end
        end
    end

    initial begin
        repeat (50000) @(posedge sys_clk);
        $display("[TB] FAIL watchdog: bench did not finish within 50000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int h;
        int l;
        sys_rst_n = 1'b0;
        en        = 1'b0;
        pol       = 1'b0;
        clr       = 1'b0;
        cap_in    = 1'b0;
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_period", period, 0);
        checkOutput("rst_high_time", high_time, 0);
        checkOutput("rst_cap_valid", cap_valid, 0);
        checkOutput("rst_ovf", ovf_flag, 0);
        checkOutput("rst_busy", busy, 0);
        sys_rst_n = 1'b1;
        idleCycles(2);
        en = 1'b1;
        idleCycles(1);
        checkOutput("arm_busy", busy, 0);
        idleCycles(3);
        rearmModel();

        // 30/70 waveform, normal polarity
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 30);
            applyStimulus(1'b0, 70);
        end
        checkDrained("drain_basic");

        // disable in the middle of LOW
        applyStimulus(1'b1, 30);
        applyStimulus(1'b0, 20);
        en = 1'b0;
        idleCycles(1);
        checkOutput("disable_busy", busy, 0);
        idleCycles(3);
        checkOutput("disable_period_held", period, 100);
        checkOutput("disable_high_held", high_time, 30);
        en = 1'b1;
        idleCycles(3);
        rearmModel();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 30);
            applyStimulus(1'b0, 70);
        end
        checkDrained("drain_reenable");

        // clr coincident with a rise detected in LOW
        cap_in = 1'b1;
        idleCycles(2);
        clr = 1'b1;
        idleCycles(1);
        clr = 1'b0;
        checkOutput("clr_period", period, 0);
        checkOutput("clr_high_time", high_time, 0);
        checkOutput("clr_ovf", ovf_flag, 0);
        checkOutput("clr_cap_valid", cap_valid, 0);
        checkOutput("clr_busy", busy, 0);
        rearmModel();
        applyStimulus(1'b1, 27);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 70);
            applyStimulus(1'b1, 30);
        end
        applyStimulus(1'b0, 70);
        checkDrained("drain_after_clr");

        // long active level overflows the 8-bit counter
        applyStimulus(1'b1, 200);
        checkOutput("ovf_before_limit", ovf_flag, 0);
        checkOutput("busy_before_limit", busy, 1);
        idleCycles(100);
        checkOutput("ovf_after_limit", ovf_flag, 1);
        checkOutput("busy_after_ovf", busy, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 20);
            applyStimulus(1'b1, 20);
        end
        applyStimulus(1'b0, 20);
        checkDrained("drain_after_ovf");
        checkOutput("ovf_sticky", ovf_flag, 1);
        clr = 1'b1;
        idleCycles(1);
        clr = 1'b0;
        checkOutput("ovf_cleared", ovf_flag, 0);
        rearmModel();

        // inverted polarity, changed while disabled
        en = 1'b0;
        idleCycles(3);
        pol = 1'b1;
        idleCycles(3);
        en = 1'b1;
        idleCycles(4);
        rearmModel();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 30);
            applyStimulus(1'b0, 70);
        end
        checkDrained("drain_pol");
        en = 1'b0;
        idleCycles(3);
        pol = 1'b0;
        idleCycles(3);
        en = 1'b1;
        idleCycles(4);
        rearmModel();

        // random duty and period
        for (int k = 0; k < 20; k++) begin
            h = int'($urandom_range(1, 120));
            l = int'($urandom_range(1, 120));
            applyStimulus(1'b1, h);
            applyStimulus(1'b0, l);
        end
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 10);
        checkDrained("drain_random");

        // asynchronous reset in the middle of HIGH
        applyStimulus(1'b1, 10);
        checkOutput("busy_before_reset", busy, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_period", period, 0);
        checkOutput("async_rst_high_time", high_time, 0);
        checkOutput("async_rst_cap_valid", cap_valid, 0);
        checkOutput("async_rst_ovf", ovf_flag, 0);
        checkOutput("async_rst_busy", busy, 0);
        cap_in = 1'b0;
        @(negedge sys_clk);
        idleCycles(2);
        sys_rst_n = 1'b1;
        idleCycles(4);
        rearmModel();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1);
            applyStimulus(1'b0, 1);
        end
        idleCycles(5);
        checkDrained("drain_min_period");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
